// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon-Says game engine.
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        EXTEND,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        WAIT_REL,
        GAP,
        WIN,
        LOSE
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // One-hot decode of a button index; callers truncate to their button count.
    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed load and advance enables.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [15:0]      seed_i,
    input  logic             advance_i,
    output logic [OUT_W-1:0] next_elem_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: shift right, fold taps in when the outgoing bit is set.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end
    end

    // LFSR register: reset/zero seed fall back to the default state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_DEFAULT;
        end else if (load_i) begin
            lfsr_q <= (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
        end else if (advance_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    // The element appended in EXTEND is taken from the post-advance value.
    assign next_elem_o = lfsr_d[OUT_W-1:0];

endmodule

// File: rtl/simon_engine.sv
// Simon-Says engine: grows a random sequence, plays it on LEDs, checks presses.
module simon_engine
    import simon_pkg::*;
#(
    parameter int N_BUTTONS     = 4,
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 2,
    parameter int OFF_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 8,
    localparam int IW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [15:0]          seed,
    input  logic [N_BUTTONS-1:0] btn,
    output logic [N_BUTTONS-1:0] leds,
    output logic                 is_player,
    output logic                 correct,
    output logic                 wrong,
    output logic                 won,
    output logic                 game_over,
    output logic [LW-1:0]        level
);

    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CM1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CMAX = (CM1 > TIMEOUT_TICKS) ? CM1 : TIMEOUT_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0] MAX_LEVEL = LW'(MAX_LEN);

    state_t                 state_q;
    logic [LW-1:0]          level_q;
    logic [LW-1:0]          idx_q;
    logic [CW-1:0]          cnt_q;
    logic                   armed_q;
    logic [N_BUTTONS-1:0]   leds_q;
    logic                   is_player_q;
    logic                   correct_q;
    logic                   wrong_q;
    logic                   won_q;
    logic                   game_over_q;
    logic [IW-1:0]          seq_q [MAX_LEN];

    logic [IW-1:0]          new_elem;
    logic [LW-1:0]          idx_inc;
    logic [N_BUTTONS-1:0]   exp_mask;
    logic [N_BUTTONS-1:0]   first_mask;
    logic [N_BUTTONS-1:0]   next_show_mask;
    logic                   accept_start;
    logic                   advance;

    assign idx_inc        = idx_q + 1'b1;
    assign exp_mask       = N_BUTTONS'(onehot(4'(seq_q[idx_q[AW-1:0]])));
    assign next_show_mask = N_BUTTONS'(onehot(4'(seq_q[idx_inc[AW-1:0]])));
    // On the first round seq[0] is being written this cycle, so bypass it.
    assign first_mask     = (level_q == '0) ? N_BUTTONS'(onehot(4'(new_elem)))
                                            : N_BUTTONS'(onehot(4'(seq_q[0])));
    assign accept_start   = start && ((state_q == IDLE) || (state_q == WIN) || (state_q == LOSE));
    assign advance        = (state_q == EXTEND);

    simon_lfsr #(
        .OUT_W(IW)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_start),
        .seed_i     (seed),
        .advance_i  (advance),
        .next_elem_o(new_elem)
    );

    // Sequence store: append the fresh element at the current length.
    always_ff @(posedge clk) begin
        if (!rst && state_q == EXTEND) begin
            seq_q[level_q[AW-1:0]] <= new_elem;
        end
    end

    // Game FSM with registered outputs updated on each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            leds_q      <= '0;
            is_player_q <= 1'b0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            won_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            case (state_q)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state_q     <= EXTEND;
                        level_q     <= '0;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        won_q       <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                end
                EXTEND: begin
                    level_q <= level_q + 1'b1;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    leds_q  <= first_mask;
                    state_q <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (tick) begin
                        if (cnt_q == ON_LAST) begin
                            cnt_q   <= '0;
                            leds_q  <= '0;
                            state_q <= SHOW_OFF;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                SHOW_OFF: begin
                    if (tick) begin
                        if (cnt_q == OFF_LAST) begin
                            cnt_q <= '0;
                            if (idx_inc < level_q) begin
                                idx_q   <= idx_inc;
                                leds_q  <= next_show_mask;
                                state_q <= SHOW_ON;
                            end else begin
                                idx_q       <= '0;
                                armed_q     <= 1'b0;
                                is_player_q <= 1'b1;
                                state_q     <= WAIT_IN;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_IN: begin
                    if (btn == '0) begin
                        armed_q <= 1'b1;
                    end
                    // A multi-press can never equal a one-hot mask, so one compare covers both loss cases.
                    if (armed_q && btn != '0) begin
                        if (btn == exp_mask) begin
                            state_q <= WAIT_REL;
                        end else begin
                            state_q     <= LOSE;
                            wrong_q     <= 1'b1;
                            game_over_q <= 1'b1;
                            is_player_q <= 1'b0;
                        end
                    end else if (btn == '0 && tick) begin
                        if (cnt_q == TO_LAST) begin
                            state_q     <= LOSE;
                            wrong_q     <= 1'b1;
                            game_over_q <= 1'b1;
                            is_player_q <= 1'b0;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (btn == '0) begin
                        idx_q <= idx_inc;
                        cnt_q <= '0;
                        if (idx_inc == level_q) begin
                            correct_q   <= 1'b1;
                            is_player_q <= 1'b0;
                            if (level_q == MAX_LEVEL) begin
                                won_q   <= 1'b1;
                                state_q <= WIN;
                            end else begin
                                state_q <= GAP;
                            end
                        end else begin
                            armed_q <= 1'b0;
                            state_q <= WAIT_IN;
                        end
                    end else if (btn != exp_mask) begin
                        state_q     <= LOSE;
                        wrong_q     <= 1'b1;
                        game_over_q <= 1'b1;
                        is_player_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_q == OFF_LAST) begin
                            cnt_q   <= '0;
                            state_q <= EXTEND;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign leds      = leds_q;
    assign is_player = is_player_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign won       = won_q;
    assign game_over = game_over_q;
    assign level     = level_q;

endmodule

// File: tb/tb_simon_engine.sv
// Directed bench for simon_engine: two instances (long game, short game).
module tb_simon_engine;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        tick, start, sel;
    logic [15:0] seed;
    logic [3:0]  btn;

    logic [3:0]  leds_a, leds_b;
    logic        is_player_a, is_player_b, correct_a, correct_b;
    logic        wrong_a, wrong_b, won_a, won_b, go_a, go_b;
    logic [5:0]  level_a;
    logic [1:0]  level_b;

    logic [3:0]  leds;
    logic        is_player, correct, wrong, won, game_over;
    logic [5:0]  level;

    int tests = 0;
    int fails = 0;
    logic [3:0] cap[$];
    logic [3:0] exp_mask [4];

    typedef struct packed {
        logic [3:0] btn;
        logic       lose;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    simon_engine #(
        .N_BUTTONS(4), .MAX_LEN(32), .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(3)
    ) dut_a (
        .clk(clk), .rst(rst_a), .tick(tick), .start(start && !sel), .seed(seed), .btn(btn),
        .leds(leds_a), .is_player(is_player_a), .correct(correct_a), .wrong(wrong_a),
        .won(won_a), .game_over(go_a), .level(level_a)
    );

    simon_engine #(
        .N_BUTTONS(4), .MAX_LEN(2), .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(8)
    ) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick), .start(start && sel), .seed(seed), .btn(btn),
        .leds(leds_b), .is_player(is_player_b), .correct(correct_b), .wrong(wrong_b),
        .won(won_b), .game_over(go_b), .level(level_b)
    );

    assign leds      = sel ? leds_b      : leds_a;
    assign is_player = sel ? is_player_b : is_player_a;
    assign correct   = sel ? correct_b   : correct_a;
    assign wrong     = sel ? wrong_b     : wrong_a;
    assign won       = sel ? won_b       : won_a;
    assign game_over = sel ? go_b        : go_a;
    assign level     = sel ? {4'b0000, level_b} : level_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_a = 1'b1; rst_b = 1'b1; start = 1'b0; btn = '0;
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic start_game(input logic [15:0] s);
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps until the player phase, recording every lit LED pattern on the way.
    task automatic wait_player();
        int n = 0;
        cap.delete();
        while (!is_player && n < 100) begin
            step();
            if (leds != '0) cap.push_back(leds);
            n++;
        end
        if (!is_player) check("wait_player_timeout", 32'(is_player), 32'd1);
    endtask

    task automatic press(input logic [3:0] b);
        btn = '0;
        step();
        btn = b;
        step();
    endtask

    task automatic play_round(input int r);
        wait_player();
        check($sformatf("r%0d_show_len", r), 32'(cap.size()), 32'(r));
        for (int i = 0; i < r && i < cap.size(); i++)
            check($sformatf("r%0d_show%0d", r, i), 32'(cap[i]), 32'(exp_mask[i]));
        check($sformatf("r%0d_level", r), 32'(level), 32'(r));
        for (int i = 0; i < r; i++) begin
            press(exp_mask[i]);
            check($sformatf("r%0d_p%0d_held", r, i), {30'd0, is_player, wrong}, 32'b10);
            btn = '0;
            step();
            check($sformatf("r%0d_p%0d_rel", r, i), 32'(correct), (i == r - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        exp_mask = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
        vecs[0] = '{btn: 4'b0001, lose: 1'b0};
        vecs[1] = '{btn: 4'b0010, lose: 1'b1};
        vecs[2] = '{btn: 4'b0011, lose: 1'b1};
        vecs[3] = '{btn: 4'b1000, lose: 1'b1};
        vecs[4] = '{btn: 4'b0101, lose: 1'b1};
        vecs[5] = '{btn: 4'b1111, lose: 1'b1};
        vecs[6] = '{btn: 4'b0100, lose: 1'b1};

        sel = 1'b0; tick = 1'b1; seed = 16'hACE1; btn = '0; start = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        step();
        start = 1'b1;
        step();
        // Reset dominates start, so both instances must still be cleared.
        check("rst_a_outs", {leds_a, is_player_a, correct_a, wrong_a, won_a, go_a, 2'b00, level_a}, 32'd0);
        check("rst_b_outs", {leds_b, is_player_b, correct_b, wrong_b, won_b, go_b, 4'b0000, level_b}, 32'd0);
        start = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;

        // Long game: echo four rounds; a start during play must be ignored.
        start_game(16'hACE1);
        check("extend_level0", 32'(level), 32'd0);
        step();
        check("first_show_leds", 32'(leds), 32'b0001);
        check("first_show_level", 32'(level), 32'd1);
        step();
        check("first_off_leds", 32'(leds), 32'd0);
        step();
        check("first_is_player", 32'(is_player), 32'd1);
        for (int i = 0; i < 1; i++) begin
            press(exp_mask[0]);
            btn = '0;
            step();
            check("r1_correct", 32'(correct), 32'd1);
        end
        step();
        check("r1_correct_pulse_end", 32'(correct), 32'd0);
        play_round(2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_level", 32'(level), 32'd2);
        play_round(3);
        play_round(4);
        check("r4_no_gameover", {30'd0, game_over, won}, 32'd0);

        // Table of first-round presses.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            start_game(16'hACE1);
            wait_player();
            press(vecs[v].btn);
            check($sformatf("vec%0d_decide", v), {29'd0, wrong, game_over, is_player},
                  vecs[v].lose ? 32'b110 : 32'b001);
            btn = '0;
            step();
            check($sformatf("vec%0d_after", v), {26'd0, correct, wrong, game_over, leds[0], level[1:0]},
                  vecs[v].lose ? 32'b001001 : 32'b100001);
        end
        // Restart from LOSE.
        start_game(16'hACE1);
        check("restart_level0", {30'd0, game_over, level[0]}, 32'd0);
        play_round(1);

        // Seeds: nonzero seed and zero-seed substitution.
        do_reset();
        start_game(16'h0003);
        wait_player();
        check("seed3_elem", (cap.size() > 0) ? 32'(cap[0]) : 32'hDEAD, 32'b0010);
        do_reset();
        start_game(16'h0000);
        wait_player();
        check("seed0_elem", (cap.size() > 0) ? 32'(cap[0]) : 32'hDEAD, 32'b0001);

        // Timeout: third tick with no press loses.
        do_reset();
        start_game(16'hACE1);
        wait_player();
        step();
        check("to_tick1", 32'(wrong), 32'd0);
        step();
        check("to_tick2", 32'(wrong), 32'd0);
        step();
        check("to_tick3", {30'd0, wrong, game_over}, 32'b11);
        step();
        check("to_pulse_end", {30'd0, wrong, game_over}, 32'b01);

        // Button held into the player phase is not a press.
        do_reset();
        btn = 4'b0001;
        start_game(16'hACE1);
        wait_player();
        step(); step(); step();
        check("held_still_wait", {30'd0, is_player, wrong}, 32'b10);
        btn = '0;
        step();
        check("held_release", {30'd0, is_player, correct}, 32'b10);
        press(4'b0001);
        btn = '0;
        step();
        check("held_then_press", 32'(correct), 32'd1);

        // Short game: win at MAX_LEN, then reset during playback.
        sel = 1'b1;
        do_reset();
        start_game(16'hACE1);
        play_round(1);
        play_round(2);
        check("win_flags", {29'd0, won, game_over, is_player}, 32'b100);
        check("win_level", 32'(level), 32'd2);
        step();
        check("win_hold", {30'd0, won, correct}, 32'b10);
        start_game(16'hACE1);
        check("win_restart", {29'd0, won, level[1:0]}, 32'd0);
        play_round(1);
        begin
            int n = 0;
            while (leds == '0 && n < 20) begin
                step();
                n++;
            end
            check("b_round2_show", 32'(leds), 32'b0001);
        end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        check("midshow_rst", {26'd0, leds, is_player, won} | {24'd0, 6'(level), 2'b00}, 32'd0);
        step();
        check("midshow_idle", {26'd0, leds, is_player, won} | {24'd0, 6'(level), 2'b00}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
